// File: rtl/rx_crc_seq.sv
// Receive-side CRC control sequencer: steers the body/tail CRC engines through each frame,
// reports one status pulse per frame and keeps saturating good/bad frame counters.
module rx_crc_seq #(
    parameter int unsigned CNT_WIDTH = 16
) (
    input  logic                 rxclk,
    input  logic                 reset,
    input  logic                 receiving_d2,
    input  logic                 get_terminator,
    input  logic [2:0]           terminator_location,
    input  logic                 crc_match,
    input  logic                 clr_counts,
    output logic                 crc64_en,
    output logic                 capture_en,
    output logic                 crc8_load,
    output logic                 crc8_en,
    output logic [2:0]           byte_sel,
    output logic                 status_valid,
    output logic                 status_good,
    output logic                 status_abort,
    output logic [CNT_WIDTH-1:0] good_cnt,
    output logic [CNT_WIDTH-1:0] bad_cnt
);

    typedef enum logic [2:0] {
        StIdle,
        StBody,
        StTail,
        StCheck,
        StReport
    } state_e;

    state_e               state_q, state_d;
    logic [2:0]           tail_len_q, tail_len_d;
    logic [2:0]           byte_sel_q, byte_sel_d;
    logic                 abort_q, abort_d;
    logic                 good_q, good_d;
    logic                 status_valid_q, status_good_q, status_abort_q;
    logic [CNT_WIDTH-1:0] good_cnt_q, good_cnt_d;
    logic [CNT_WIDTH-1:0] bad_cnt_q, bad_cnt_d;
    logic                 in_frame;

    // Terminators and valid words only matter before the tail has been captured.
    assign in_frame   = (state_q == StIdle) || (state_q == StBody);
    assign crc64_en   = receiving_d2 & ~get_terminator & in_frame;
    assign capture_en = get_terminator & in_frame;
    assign crc8_load  = get_terminator & in_frame;
    assign crc8_en    = (state_q == StTail);
    assign byte_sel   = byte_sel_q;

    assign status_valid = status_valid_q;
    assign status_good  = status_good_q;
    assign status_abort = status_abort_q;
    assign good_cnt     = good_cnt_q;
    assign bad_cnt      = bad_cnt_q;

    always_comb begin
        state_d    = state_q;
        tail_len_d = tail_len_q;
        byte_sel_d = byte_sel_q;
        abort_d    = abort_q;
        good_d     = good_q;
        good_cnt_d = good_cnt_q;
        bad_cnt_d  = bad_cnt_q;

        unique case (state_q)
            StIdle: begin
                if (get_terminator) begin
                    tail_len_d = terminator_location;
                    byte_sel_d = 3'd0;
                    state_d    = (terminator_location != 3'd0) ? StTail : StCheck;
                end else if (receiving_d2) begin
                    state_d = StBody;
                end
            end
            StBody: begin
                if (get_terminator) begin
                    tail_len_d = terminator_location;
                    byte_sel_d = 3'd0;
                    state_d    = (terminator_location != 3'd0) ? StTail : StCheck;
                end else if (!receiving_d2) begin
                    abort_d = 1'b1;
                    state_d = StReport;
                end
            end
            StTail: begin
                if (byte_sel_q == tail_len_q - 3'd1) begin
                    byte_sel_d = 3'd0;
                    state_d    = StCheck;
                end else begin
                    byte_sel_d = byte_sel_q + 3'd1;
                end
            end
            StCheck: begin
                good_d  = crc_match;
                state_d = StReport;
            end
            StReport: begin
                if (good_q && !abort_q) begin
                    if (good_cnt_q != '1) good_cnt_d = good_cnt_q + CNT_WIDTH'(1);
                end else begin
                    if (bad_cnt_q != '1) bad_cnt_d = bad_cnt_q + CNT_WIDTH'(1);
                end
                abort_d = 1'b0;
                good_d  = 1'b0;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        // Clear wins over an increment in the same cycle.
        if (clr_counts) begin
            good_cnt_d = '0;
            bad_cnt_d  = '0;
        end
    end

    always_ff @(posedge rxclk or posedge reset) begin
        if (reset) begin
            state_q        <= StIdle;
            tail_len_q     <= 3'd0;
            byte_sel_q     <= 3'd0;
            abort_q        <= 1'b0;
            good_q         <= 1'b0;
            status_valid_q <= 1'b0;
            status_good_q  <= 1'b0;
            status_abort_q <= 1'b0;
            good_cnt_q     <= '0;
            bad_cnt_q      <= '0;
        end else begin
            state_q        <= state_d;
            tail_len_q     <= tail_len_d;
            byte_sel_q     <= byte_sel_d;
            abort_q        <= abort_d;
            good_q         <= good_d;
            // Status registers line up with the REPORT cycle itself.
            status_valid_q <= (state_d == StReport);
            status_good_q  <= (state_d == StReport) & good_d & ~abort_d;
            status_abort_q <= (state_d == StReport) & abort_d;
            good_cnt_q     <= good_cnt_d;
            bad_cnt_q      <= bad_cnt_d;
        end
    end

endmodule
